model: RTL and testbench
========================

// Module: model
//
// PURPOSE
//   Free-running N-bit Gray-code counter. Advances one Gray code per clock
//   edge after reset, so exactly one output bit toggles per cycle. Used as a
//   glitch-safe sequence source, e.g. for pointers crossing clock domains.
//
// PARAMETERS
//   DATA_WIDTH  default 4  counter/output width in bits; legal range >= 2
//
// PORTS
//   clk     input   1           single clock; all state updates on rising edge
//   resetn  input   1           asynchronous, active-low reset
//   out     output  DATA_WIDTH  current Gray-code count, driven directly from flops
//
// BEHAVIOUR
//   - One clock domain. Reset is asynchronous and active-low.
//   - Internal state: binary counter bin[DATA_WIDTH-1:0] plus output register.
//   - Reset: while resetn=0, bin=0 and out=0 immediately, without waiting for
//     a clock edge. The state holds at 0 for as long as reset is asserted.
//   - Count: on each rising clk edge with resetn=1:
//       bin <= bin + 1 (mod 2^DATA_WIDTH)
//       out <= (bin+1) ^ ((bin+1) >> 1)
//     After the k-th rising edge following reset release, out = gray(k mod 2^N).
//   - Latency: first edge after release gives out=gray(1). No enable and no
//     stall exist; the counter advances on every edge.
//   - Out is always registered. No combinational path runs from any input to
//     out, except the asynchronous clear.
//   - Hamming distance between consecutive out values is exactly 1, including
//     at wrap.
//   - Wrap: bin 2^N-1 -> 0. For N=4, out goes 1000 -> 0000 with no extra
//     cycle and no hold.
//   - Reset mid-count: asserting resetn=0 forces out=0 asynchronously. The
//     count restarts from gray(1) on the first edge after deassertion.
//   - Reset deasserted coincident with a clk edge: that edge counts
//     (matches TESTING step 2). Deassertion is synchronised upstream.
//   - No X is propagated: all flops are covered by the reset.
//
// TESTING
//   1. resetn=0, one clk edge, sample #1 -> out=0000.
//   2. resetn=1, sample after each of next 2 edges -> out=0001, then 0011.
//   3. Run 16 edges from reset -> sequence 0001,0011,0010,0110,0111,0101,
//      0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
//   4. Check every consecutive pair over 40 cycles -> popcount(prev^out)==1,
//      including the 1000->0000 wrap.
//   5. Pull resetn low mid-cycle at out=0110, with no clk edge -> out=0000
//      immediately. Release it -> next edge gives 0001.
//   6. DATA_WIDTH=6: run 64 edges -> all 64 codes are unique and out returns
//      to 000000.

Source files
------------

// File: rtl/model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | model : free-running Gray-code counter, one output bit toggles per clock |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module model #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic [DATA_WIDTH-1:0] out
);

  localparam logic [DATA_WIDTH-1:0] c_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_bin;
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] w_bin_next;
  logic [DATA_WIDTH-1:0] w_gray_next;

  // The Gray code is formed from the incremented binary value, so the
  // registered output tracks the binary counter with no extra cycle of lag.
  assign w_bin_next  = r_bin + c_ONE;
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bin <= '0;
      r_out <= '0;
    end else begin
      r_bin <= w_bin_next;
      r_out <= w_gray_next;
    end
  end

  assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_model : directed, table-driven bench for the Gray-code counter        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_model;

  logic       clk;
  logic       resetn;
  logic [3:0] out4;
  logic [5:0] out6;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         edge_no;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [16];

  model #(.DATA_WIDTH(4)) u_dut4 (.clk(clk), .resetn(resetn), .out(out4));
  model #(.DATA_WIDTH(6)) u_dut6 (.clk(clk), .resetn(resetn), .out(out6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev4;
    bit         seen6 [64];
    int         uniq6;

    vecs[0]  = '{1,  4'b0001}; vecs[1]  = '{2,  4'b0011};
    vecs[2]  = '{3,  4'b0010}; vecs[3]  = '{4,  4'b0110};
    vecs[4]  = '{5,  4'b0111}; vecs[5]  = '{6,  4'b0101};
    vecs[6]  = '{7,  4'b0100}; vecs[7]  = '{8,  4'b1100};
    vecs[8]  = '{9,  4'b1101}; vecs[9]  = '{10, 4'b1111};
    vecs[10] = '{11, 4'b1110}; vecs[11] = '{12, 4'b1010};
    vecs[12] = '{13, 4'b1011}; vecs[13] = '{14, 4'b1001};
    vecs[14] = '{15, 4'b1000}; vecs[15] = '{16, 4'b0000};

    // Reset held across an edge
    resetn = 1'b0;
    tick();
    check("reset4", {4'b0, out4}, 8'h00);
    check("reset6", {2'b0, out6}, 8'h00);

    @(negedge clk);
    resetn = 1'b1;
    prev4 = out4;
    uniq6 = 0;
    for (int i = 0; i < 64; i++) seen6[i] = 1'b0;

    // 64 edges: 16-entry table, 40-cycle one-bit-change check, 6-bit coverage
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k <= 16) begin
        check($sformatf("seq_edge%0d", vecs[k-1].edge_no), {4'b0, out4}, {4'b0, vecs[k-1].exp});
      end
      if (k <= 40) begin
        check($sformatf("hamming_edge%0d", k), 8'($countones(prev4 ^ out4)), 8'd1);
      end
      prev4 = out4;
      if (!seen6[out6]) uniq6++;
      seen6[out6] = 1'b1;
    end
    check("w6_unique", 8'(uniq6), 8'd64);
    check("w6_wrap",   {2'b0, out6}, 8'h00);

    // Asynchronous reset mid-count at 0110
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_async_setup", {4'b0, out4}, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("pre_reset_0110", {4'b0, out4}, 8'h06);
    #3;
    resetn = 1'b0;
    #1;
    check("async_clear", {4'b0, out4}, 8'h00);
    tick();
    check("reset_hold", {4'b0, out4}, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("restart_g1", {4'b0, out4}, 8'h01);
    tick();
    check("restart_g2", {4'b0, out4}, 8'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
